// File: rtl/conv_gemm.sv
// conv_gemm: dot product of im2col rows against filter weights, one result per (filter, pixel).
// Latency: FILTER_NUM*((K+1) + P*(K+2)) cycles from the first LOAD_W cycle to DONE; reads have a fixed 1-cycle latency.
// Backpressure: none. The memory must accept one read and one write per cycle; start is honoured only in IDLE.
module conv_gemm #(
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int ACC_WIDTH   = 32,
  parameter int FILTER_SIZE = 3,
  parameter int FILTER_NUM  = 2,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 'h4000,
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE    = 'h6000
) (
  input  logic                  clk,
  input  logic                  rst_conv_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [ACC_WIDTH-1:0]  data_wr,
  output logic                  mem_wr_en,
  output logic                  busy,
  output logic                  conv_done
);

  localparam int K  = FILTER_SIZE * FILTER_SIZE;
  localparam int P  = IMG_W * IMG_H;
  localparam int KW = $clog2(K + 1);
  localparam int PW = $clog2(P + 1);
  localparam int FW = $clog2(FILTER_NUM + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, MAC, WRITE, DONE} state_t;

  state_t                state, state_nxt;
  logic [FW-1:0]         f, f_nxt;
  logic [PW-1:0]         p, p_nxt;
  logic [KW-1:0]         k, k_nxt;
  logic [ACC_WIDTH-1:0]  acc, acc_nxt;
  logic [DATA_WIDTH-1:0] wreg [K];

  // data_rd always belongs to the tap issued one cycle earlier, hence k-1
  logic [KW-1:0]                tap;
  logic signed [DATA_WIDTH-1:0] opnd_a, opnd_w;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]         prod_ext;

  assign tap      = (k == '0) ? '0 : k - KW'(1);
  assign opnd_a   = data_rd;
  assign opnd_w   = wreg[tap];
  assign prod     = opnd_a * opnd_w;
  assign prod_ext = ACC_WIDTH'($signed(prod));

  function automatic logic [ADDR_WIDTH-1:0] addr_of(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [ADDR_WIDTH-1:0] row,
    input logic [ADDR_WIDTH-1:0] stride,
    input logic [ADDR_WIDTH-1:0] col
  );
    return base + row * stride + col;
  endfunction

  // next-state, counter and accumulator logic
  always_comb begin
    state_nxt = state;
    f_nxt     = f;
    p_nxt     = p;
    k_nxt     = k;
    acc_nxt   = acc;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_W;
          f_nxt     = '0;
          p_nxt     = '0;
          k_nxt     = '0;
        end
      end
      LOAD_W: begin
        if (k == KW'(K)) begin
          state_nxt = MAC;
          p_nxt     = '0;
          k_nxt     = '0;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      MAC: begin
        if (k == KW'(1)) begin
          acc_nxt = prod_ext;
        end else if (k > KW'(1)) begin
          acc_nxt = acc + prod_ext;
        end
        if (k == KW'(K)) begin
          state_nxt = WRITE;
          k_nxt     = '0;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      WRITE: begin
        k_nxt = '0;
        if (p < PW'(P - 1)) begin
          state_nxt = MAC;
          p_nxt     = p + PW'(1);
        end else if (f < FW'(FILTER_NUM - 1)) begin
          state_nxt = LOAD_W;
          f_nxt     = f + FW'(1);
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // state, counters and accumulator
  always_ff @(posedge clk) begin
    if (!rst_conv_n) begin
      state <= IDLE;
      f     <= '0;
      p     <= '0;
      k     <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      f     <= f_nxt;
      p     <= p_nxt;
      k     <= k_nxt;
      acc   <= acc_nxt;
    end
  end

  // capture the filter taps as they return during LOAD_W
  always_ff @(posedge clk) begin
    if (!rst_conv_n) begin
      for (int i = 0; i < K; i++) begin
        wreg[i] <= '0;
      end
    end else if (state == LOAD_W && k != '0) begin
      wreg[tap] <= data_rd;
    end
  end

  // outputs are registered from next-state values so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (!rst_conv_n) begin
      addr_rd   <= '0;
      addr_wr   <= '0;
      data_wr   <= '0;
      mem_wr_en <= 1'b0;
      busy      <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      conv_done <= (state_nxt == DONE);
      mem_wr_en <= (state_nxt == WRITE);
      if (state_nxt == WRITE) begin
        addr_wr <= addr_of(OUT_BASE, ADDR_WIDTH'(f_nxt), ADDR_WIDTH'(P), ADDR_WIDTH'(p_nxt));
        data_wr <= acc_nxt;
      end
      if (state_nxt == LOAD_W && k_nxt < KW'(K)) begin
        addr_rd <= addr_of(WEIGHT_BASE, ADDR_WIDTH'(f_nxt), ADDR_WIDTH'(K), ADDR_WIDTH'(k_nxt));
      end else if (state_nxt == MAC && k_nxt < KW'(K)) begin
        addr_rd <= addr_of(IM2COL_BASE, ADDR_WIDTH'(p_nxt), ADDR_WIDTH'(K), ADDR_WIDTH'(k_nxt));
      end
    end
  end

endmodule

// File: tb/tb_conv_gemm.sv
// tb_conv_gemm: directed checks of conv_gemm at defaults plus a 16-bit accumulator instance.
// Memory model answers reads one cycle after the address; writes are logged by a negedge monitor.
// Expected results are hand-derived from the stored weight and im2col patterns.
module tb_conv_gemm;

  logic        clk = 1'b0;
  logic        rst_conv_n = 1'b0;
  logic        start = 1'b0;
  logic        start16 = 1'b0;
  logic [7:0]  data_rd = '0;
  logic [7:0]  data_rd16 = '0;
  logic [31:0] addr_rd, addr_wr, data_wr;
  logic [31:0] addr_rd16, addr_wr16;
  logic [15:0] data_wr16;
  logic        mem_wr_en, busy, conv_done;
  logic        mem_wr_en16, busy16, conv_done16;

  always #5 clk = ~clk;

  conv_gemm dut (
    .clk(clk), .rst_conv_n(rst_conv_n), .start(start), .data_rd(data_rd),
    .addr_rd(addr_rd), .addr_wr(addr_wr), .data_wr(data_wr),
    .mem_wr_en(mem_wr_en), .busy(busy), .conv_done(conv_done)
  );

  conv_gemm #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_conv_n(rst_conv_n), .start(start16), .data_rd(data_rd16),
    .addr_rd(addr_rd16), .addr_wr(addr_wr16), .data_wr(data_wr16),
    .mem_wr_en(mem_wr_en16), .busy(busy16), .conv_done(conv_done16)
  );

  // shared memory image
  logic [7:0] wmem [18];
  logic [7:0] imem [576];

  function automatic logic [7:0] rd(input logic [31:0] a);
    int off;
    off = int'(a);
    if (off >= 'h4000 && off < 'h4000 + 18) return wmem[off - 'h4000];
    if (off >= 'h2000 && off < 'h2000 + 576) return imem[off - 'h2000];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    data_rd   <= rd(addr_rd);
    data_rd16 <= rd(addr_rd16);
  end

  // write log and event monitor
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          wr_cnt = 0, done_cnt = 0, dbl_wr = 0;
  int          busy_rise_cyc = 0, done_cyc = 0;
  int          wr16_cnt = 0, bad16 = 0, done16_cnt = 0;
  logic        busy_at_done = 1'b0;
  logic        prev_wr = 1'b0, prev_busy = 1'b0;
  logic [31:0] wr_addr [128];
  logic [31:0] wr_dat  [128];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_wr_en) begin
      if (wr_cnt < 128) begin
        wr_addr[wr_cnt] = addr_wr;
        wr_dat[wr_cnt]  = data_wr;
      end
      if (prev_wr) dbl_wr = dbl_wr + 1;
      wr_cnt = wr_cnt + 1;
    end
    prev_wr = mem_wr_en;
    if (busy && !prev_busy) busy_rise_cyc = cyc;
    prev_busy = busy;
    if (conv_done) begin
      done_cnt     = done_cnt + 1;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (mem_wr_en16) begin
      wr16_cnt = wr16_cnt + 1;
      if (data_wr16 !== 16'h4000) bad16 = bad16 + 1;
    end
    if (conv_done16) done16_cnt = done16_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] d);
    for (int i = 0; i < 18; i++) wmem[i] = (i < 9) ? w0 : w1;
    for (int i = 0; i < 576; i++) imem[i] = d;
  endtask

  task automatic clear_log();
    wr_cnt = 0; done_cnt = 0; dbl_wr = 0;
    for (int i = 0; i < 128; i++) begin
      wr_addr[i] = 'x;
      wr_dat[i]  = 'x;
    end
  endtask

  // pulse start, optionally re-pulse it once wr_cnt reaches mid_at, and wait for conv_done
  task automatic run_job(input string tag, input int mid_at);
    bit pulsed;
    int budget;
    pulsed = 0;
    clear_log();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    budget = 3000;
    while (done_cnt == 0 && budget > 0) begin
      tick(1);
      budget = budget - 1;
      if (mid_at >= 0 && !pulsed && wr_cnt == mid_at) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
        pulsed = 1;
      end
    end
    check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    tick(30);
  endtask

  task automatic verify_job(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    int bad_addr, bad_dat;
    logic [31:0] ea, ed;
    bad_addr = 0;
    bad_dat  = 0;
    for (int i = 0; i < 128; i++) begin
      ea = 32'h6000 + 32'(i);
      ed = (i < 64) ? e0 : e1;
      if (wr_addr[i] !== ea) bad_addr = bad_addr + 1;
      if (wr_dat[i] !== ed) bad_dat = bad_dat + 1;
    end
    check({tag, "_writes"}, 32'(wr_cnt), 32'd128);
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_single_strobe"}, 32'(dbl_wr), 32'd0);
    check({tag, "_addr_seq_bad"}, 32'(bad_addr), 32'd0);
    check({tag, "_data_bad"}, 32'(bad_dat), 32'd0);
    check({tag, "_first_addr"}, wr_addr[0], 32'h6000);
    check({tag, "_last_addr"}, wr_addr[127], 32'h607F);
    check({tag, "_first_dat"}, wr_dat[0], e0);
    check({tag, "_last_dat"}, wr_dat[127], e1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, observed cycle %0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;

    // reset state
    fill(8'd1, 8'd1, 8'd1);
    tick(3);
    check("rst_addr_rd", addr_rd, 32'd0);
    check("rst_addr_wr", addr_wr, 32'd0);
    check("rst_data_wr", data_wr, 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(conv_done), 32'd0);
    rst_conv_n = 1'b1;
    tick(2);

    // all ones: 9 taps of 1*1 = 9 everywhere; first weight address issued on LOAD_W entry
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ones_busy_rise", 32'(busy), 32'd1);
    check("ones_first_rd_addr", addr_rd, 32'h4000);
    clear_log();
    budget = 3000;
    while (done_cnt == 0 && budget > 0) begin
      tick(1);
      budget = budget - 1;
    end
    check("ones_done_seen", 32'(done_cnt > 0), 32'd1);
    tick(30);
    verify_job("ones", 32'd9, 32'd9);
    check("ones_cycle_count", 32'(done_cyc - busy_rise_cyc), 32'd1428);
    check("ones_busy_at_done", 32'(busy_at_done), 32'd1);
    check("ones_idle_after", 32'(busy), 32'd0);

    // start re-pulsed mid-job at pixel 10 is ignored
    run_job("restart", 10);
    verify_job("restart", 32'd9, 32'd9);
    check("restart_cycle_count", 32'(done_cyc - busy_rise_cyc), 32'd1428);

    // reset during MAC of pixel 20 aborts, then a fresh job runs cleanly
    clear_log();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    budget = 3000;
    while (wr_cnt < 20 && budget > 0) begin
      tick(1);
      budget = budget - 1;
    end
    check("abort_reached_p20", 32'(wr_cnt), 32'd20);
    tick(3);
    rst_conv_n = 1'b0;
    tick(1);
    check("abort_addr_rd", addr_rd, 32'd0);
    check("abort_addr_wr", addr_wr, 32'd0);
    check("abort_data_wr", data_wr, 32'd0);
    check("abort_wr_en", 32'(mem_wr_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(conv_done), 32'd0);
    tick(2);
    rst_conv_n = 1'b1;
    tick(5);
    check("abort_no_more_writes", 32'(wr_cnt), 32'd20);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_job("rerun", -1);
    verify_job("rerun", 32'd9, 32'd9);

    // filter 0 weights -1, filter 1 weights 2, data 127: 9*-127 = -1143, 9*254 = 2286
    fill(8'hFF, 8'd2, 8'd127);
    run_job("signed", -1);
    verify_job("signed", 32'hFFFF_FB89, 32'd2286);

    // 16-bit accumulator: 9 * (-128 * -128) = 147456, wraps to 0x4000
    fill(8'h80, 8'h80, 8'h80);
    wr16_cnt = 0; bad16 = 0; done16_cnt = 0;
    start16 = 1'b1;
    tick(1);
    start16 = 1'b0;
    check("acc16_busy_rise", 32'(busy16), 32'd1);
    budget = 3000;
    while (done16_cnt == 0 && budget > 0) begin
      tick(1);
      budget = budget - 1;
    end
    tick(10);
    check("acc16_done_once", 32'(done16_cnt), 32'd1);
    check("acc16_writes", 32'(wr16_cnt), 32'd128);
    check("acc16_bad_data", 32'(bad16), 32'd0);
    check("acc16_last_dat", 32'(data_wr16), 32'h4000);
    check("acc16_last_addr", addr_wr16, 32'h607F);
    check("acc16_main_idle", 32'(wr_cnt), 32'd128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
